// File: rtl/risc_regfile_pkg.sv
// Shared defaults and load-scoreboard FSM encoding for the RISC register file.
package risc_regfile_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  // Load scoreboard state: idle, or one load outstanding.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ld_state_e;

endpackage : risc_regfile_pkg

// File: rtl/risc_ld_scoreboard.sv
// Single-outstanding-load scoreboard.
// Tracks the pending load destination, the per-register busy bits and whether a
// younger ALU write has superseded the load.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reg_wr_vld, dst            ALU writeback strobe / target
//   ld_issue, ld_dst           load issue / destination
//   ld_rsp_vld                 load data returning
//   ld_issue_rdy               load may be accepted this cycle (combinational)
//   ld_we                      returning load data should be written (combinational)
//   pend_dst                   destination of the outstanding load
//   busy_vec                   per-register pending-load bits
module risc_ld_scoreboard
  import risc_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = (1 << ADDR_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_wr_vld,
  input  logic [ADDR_W-1:0]   dst,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_dst,
  input  logic                ld_rsp_vld,
  output logic                ld_issue_rdy,
  output logic                ld_we,
  output logic [ADDR_W-1:0]   pend_dst,
  output logic [NUM_REGS-1:0] busy_vec
);

  ld_state_e state;
  logic      squash;
  logic      alu_hit;

  // ALU write to the register the outstanding load targets.
  assign alu_hit      = reg_wr_vld & (dst == pend_dst);
  assign ld_issue_rdy = (state == ST_IDLE) | ld_rsp_vld;
  // A squashed load, or one colliding with a same-cycle ALU write, is dropped.
  assign ld_we        = (state == ST_PEND) & ld_rsp_vld & ~squash & ~alu_hit;

  // Scoreboard state; a same-cycle re-issue overrides the response's busy clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pend_dst <= '0;
      squash   <= 1'b0;
      busy_vec <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_issue) begin
            pend_dst <= ld_dst;
            busy_vec <= NUM_REGS'(1) << ld_dst;
            squash   <= 1'b0;
            state    <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (alu_hit) squash <= 1'b1;
          if (ld_rsp_vld) begin
            if (ld_issue) begin
              pend_dst <= ld_dst;
              busy_vec <= NUM_REGS'(1) << ld_dst;
              squash   <= 1'b0;
            end else begin
              busy_vec <= '0;
              state    <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule : risc_ld_scoreboard

// File: rtl/risc_regfile_sb.sv
// Register file with a single-outstanding-load scoreboard.
// ALU writeback lands at the clock edge; load data returns later and is written
// unless a younger ALU write to the same register superseded it.
// Optional feature: define RISC_REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports (ALU data first, then unsquashed load data).
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reg_wr_vld, dst, rslt           ALU writeback
//   ld_issue, ld_dst                load issue
//   ld_rsp_vld, dmdataout           load response
//   opnda_addr, opndb_addr          read addresses
//   oprnd_a, oprnd_b                read data (combinational)
//   opnd_stall                      an operand addresses a busy register
//   ld_issue_rdy                    load can be accepted this cycle
//   busy_vec                        per-register pending-load bits
module risc_regfile_sb
  import risc_regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_REGS = (1 << ADDR_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reg_wr_vld,
  input  logic [ADDR_W-1:0]   dst,
  input  logic [DATA_W-1:0]   rslt,
  input  logic                ld_issue,
  input  logic [ADDR_W-1:0]   ld_dst,
  input  logic                ld_rsp_vld,
  input  logic [DATA_W-1:0]   dmdataout,
  input  logic [ADDR_W-1:0]   opnda_addr,
  input  logic [ADDR_W-1:0]   opndb_addr,
  output logic [DATA_W-1:0]   oprnd_a,
  output logic [DATA_W-1:0]   oprnd_b,
  output logic                opnd_stall,
  output logic                ld_issue_rdy,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              ld_we;
  logic [ADDR_W-1:0] pend_dst;
  logic              stall_a;
  logic              stall_b;

  risc_ld_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_wr_vld   (reg_wr_vld),
    .dst          (dst),
    .ld_issue     (ld_issue),
    .ld_dst       (ld_dst),
    .ld_rsp_vld   (ld_rsp_vld),
    .ld_issue_rdy (ld_issue_rdy),
    .ld_we        (ld_we),
    .pend_dst     (pend_dst),
    .busy_vec     (busy_vec)
  );

  // Register array; the ALU write has priority over load data on the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (reg_wr_vld && (dst == ADDR_W'(i)))
          regs[i] <= rslt;
        else if (ld_we && (pend_dst == ADDR_W'(i)))
          regs[i] <= dmdataout;
      end
    end
  end

`ifdef RISC_REGFILE_BYPASS_EN
  logic alu_fwd;
  // No forwarding while held in reset so the read ports stay at zero.
  assign alu_fwd = reg_wr_vld & rst_n;

  // Read ports with same-cycle forwarding; forwarded load data is no longer a hazard.
  always_comb begin
    oprnd_a = regs[opnda_addr];
    stall_a = busy_vec[opnda_addr];
    if (alu_fwd && (dst == opnda_addr)) begin
      oprnd_a = rslt;
    end else if (ld_we && (pend_dst == opnda_addr)) begin
      oprnd_a = dmdataout;
      stall_a = 1'b0;
    end
  end

  always_comb begin
    oprnd_b = regs[opndb_addr];
    stall_b = busy_vec[opndb_addr];
    if (alu_fwd && (dst == opndb_addr)) begin
      oprnd_b = rslt;
    end else if (ld_we && (pend_dst == opndb_addr)) begin
      oprnd_b = dmdataout;
      stall_b = 1'b0;
    end
  end
`else
  // Read ports return pre-edge contents.
  assign oprnd_a = regs[opnda_addr];
  assign oprnd_b = regs[opndb_addr];
  assign stall_a = busy_vec[opnda_addr];
  assign stall_b = busy_vec[opndb_addr];
`endif

  assign opnd_stall = stall_a | stall_b;

endmodule : risc_regfile_sb

// File: tb/tb_risc_regfile_sb.sv
// Randomized self-checking bench for risc_regfile_sb against a transaction-level model.
module tb_risc_regfile_sb;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reg_wr_vld = 1'b0;
  logic [AW-1:0] dst = '0;
  logic [DW-1:0] rslt = '0;
  logic          ld_issue = 1'b0;
  logic [AW-1:0] ld_dst = '0;
  logic          ld_rsp_vld = 1'b0;
  logic [DW-1:0] dmdataout = '0;
  logic [AW-1:0] opnda_addr = '0;
  logic [AW-1:0] opndb_addr = '0;
  logic [DW-1:0] oprnd_a;
  logic [DW-1:0] oprnd_b;
  logic          opnd_stall;
  logic          ld_issue_rdy;
  logic [NR-1:0] busy_vec;

  risc_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_wr_vld   (reg_wr_vld),
    .dst          (dst),
    .rslt         (rslt),
    .ld_issue     (ld_issue),
    .ld_dst       (ld_dst),
    .ld_rsp_vld   (ld_rsp_vld),
    .dmdataout    (dmdataout),
    .opnda_addr   (opnda_addr),
    .opndb_addr   (opndb_addr),
    .oprnd_a      (oprnd_a),
    .oprnd_b      (oprnd_b),
    .opnd_stall   (opnd_stall),
    .ld_issue_rdy (ld_issue_rdy),
    .busy_vec     (busy_vec)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: register contents plus at most one outstanding load record.
  logic [DW-1:0] m_regs [NR];
  bit            m_pend;
  int            m_pdst;
  bit            m_drop;
  bit            m_bypass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
    m_pend = 0;
    m_pdst = 0;
    m_drop = 0;
  endtask

  // Apply one cycle of inputs, check combinational outputs, then advance the model.
  task automatic step(input bit wr, input int d, input logic [DW-1:0] r,
                      input bit iss, input int ld, input bit rsp,
                      input logic [DW-1:0] dm, input int ra, input int rb);
    bit            rdy, load_lands, st_a, st_b;
    logic [DW-1:0] va, vb;
    logic [NR-1:0] busy;
    @(negedge clk);
    reg_wr_vld = wr;  dst = AW'(d);  rslt = r;
    ld_issue = iss;   ld_dst = AW'(ld);
    ld_rsp_vld = rsp; dmdataout = dm;
    opnda_addr = AW'(ra); opndb_addr = AW'(rb);
    #1;
    rdy        = !m_pend || rsp;
    load_lands = m_pend && rsp && !m_drop && !(wr && d == m_pdst);
    busy       = m_pend ? NR'(1) << m_pdst : '0;
    va = m_regs[ra]; st_a = busy[ra];
    vb = m_regs[rb]; st_b = busy[rb];
    if (m_bypass) begin
      if (wr && d == ra) va = r;
      else if (load_lands && m_pdst == ra) begin va = dm; st_a = 0; end
      if (wr && d == rb) vb = r;
      else if (load_lands && m_pdst == rb) begin vb = dm; st_b = 0; end
    end
    chk("oprnd_a", 32'(oprnd_a), 32'(va));
    chk("oprnd_b", 32'(oprnd_b), 32'(vb));
    chk("opnd_stall", 32'(opnd_stall), 32'(st_a | st_b));
    chk("ld_issue_rdy", 32'(ld_issue_rdy), 32'(rdy));
    chk("busy_vec", 32'(busy_vec), 32'(busy));
    // Load data first so a same-cycle ALU write to that register overrides it.
    if (load_lands) m_regs[m_pdst] = dm;
    if (wr) m_regs[d] = r;
    if (m_pend && wr && d == m_pdst) m_drop = 1;
    if (m_pend && rsp) m_pend = 0;
    if (iss && rdy) begin m_pend = 1; m_pdst = ld; m_drop = 0; end
  endtask

  task automatic idle_rd(input int ra, input int rb);
    step(0, 0, '0, 0, 0, 0, '0, ra, rb);
  endtask

  // Hold reset for a cycle with random inputs; outputs must read as reset values.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    reg_wr_vld = 1'($urandom); dst = AW'($urandom); rslt = DW'($urandom);
    ld_rsp_vld = 1'($urandom); dmdataout = DW'($urandom);
    ld_issue = 1'($urandom); ld_dst = AW'($urandom);
    opnda_addr = AW'($urandom); opndb_addr = AW'($urandom);
    #1;
    chk("rst_oprnd_a", 32'(oprnd_a), 32'd0);
    chk("rst_oprnd_b", 32'(oprnd_b), 32'd0);
    chk("rst_stall", 32'(opnd_stall), 32'd0);
    chk("rst_rdy", 32'(ld_issue_rdy), 32'd1);
    chk("rst_busy", 32'(busy_vec), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    reg_wr_vld = 0; ld_issue = 0; ld_rsp_vld = 0;
  endtask

  initial begin
`ifdef RISC_REGFILE_BYPASS_EN
    m_bypass = 1;
`else
    m_bypass = 0;
`endif
    model_reset();
    do_reset();

    // ALU write visible next cycle
    step(1, 3, 8'hA5, 0, 0, 0, '0, 3, 0);
    idle_rd(3, 0);
    chk("t1_r3", 32'(oprnd_a), 32'hA5);
    chk("t1_stall", 32'(opnd_stall), 32'd0);

    // Load to r5, then response
    step(0, 0, '0, 1, 5, 0, '0, 0, 0);
    idle_rd(5, 0);
    chk("t2_busy", 32'(busy_vec), 32'h20);
    chk("t2_stall", 32'(opnd_stall), 32'd1);
    chk("t2_rdy", 32'(ld_issue_rdy), 32'd0);
    step(0, 0, '0, 0, 0, 1, 8'h3C, 5, 0);
    idle_rd(5, 0);
    chk("t2_r5", 32'(oprnd_a), 32'h3C);
    chk("t2_busy0", 32'(busy_vec), 32'd0);
    chk("t2_rdy1", 32'(ld_issue_rdy), 32'd1);

    // Squash by younger ALU write
    step(0, 0, '0, 1, 2, 0, '0, 0, 0);
    step(1, 2, 8'h11, 0, 0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0, 1, 8'h99, 0, 0);
    idle_rd(2, 0);
    chk("t3_r2", 32'(oprnd_a), 32'h11);
    chk("t3_busy", 32'(busy_vec), 32'd0);

    // Same-cycle collision, then disjoint writes
    step(0, 0, '0, 1, 4, 0, '0, 0, 0);
    step(1, 4, 8'hEE, 0, 0, 1, 8'h77, 0, 0);
    idle_rd(4, 0);
    chk("t4_r4", 32'(oprnd_a), 32'hEE);
    step(0, 0, '0, 1, 4, 0, '0, 0, 0);
    step(1, 1, 8'hEE, 0, 0, 1, 8'h77, 0, 0);
    idle_rd(1, 4);
    chk("t4_r1", 32'(oprnd_a), 32'hEE);
    chk("t4_r4b", 32'(oprnd_b), 32'h77);

    // Back-to-back load to the same register
    step(0, 0, '0, 1, 6, 0, '0, 0, 0);
    step(0, 0, '0, 1, 6, 1, 8'h10, 0, 0);
    idle_rd(6, 0);
    chk("t5_r6", 32'(oprnd_a), 32'h10);
    chk("t5_busy", 32'(busy_vec), 32'h40);
    chk("t5_rdy", 32'(ld_issue_rdy), 32'd0);
    step(0, 0, '0, 0, 0, 1, 8'h20, 0, 0);
    idle_rd(6, 0);
    chk("t5_r6b", 32'(oprnd_a), 32'h20);

    // Reset mid-load, late response ignored
    step(0, 0, '0, 1, 7, 0, '0, 0, 0);
    do_reset();
    step(0, 0, '0, 0, 0, 1, 8'hFF, 7, 7);
    idle_rd(7, 0);
    chk("t6_r7", 32'(oprnd_a), 32'd0);
    chk("t6_busy", 32'(busy_vec), 32'd0);
    chk("t6_rdy", 32'(ld_issue_rdy), 32'd1);

    // Same-cycle read of a written register
    step(1, 3, 8'h5A, 0, 0, 0, '0, 3, 3);
    chk("t6_fwd", 32'(oprnd_a), m_bypass ? 32'h5A : 32'd0);

    // Random traffic, addresses biased to collide often
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step(($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)), DW'($urandom),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0), DW'($urandom),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_risc_regfile_sb
